// File: rtl/capture_ctrl.sv
// Trigger/capture controller: turns qualified samples into capture-RAM writes around a trigger.
// Pre-trigger fill, runtime post-trigger length, single-shot or continuous re-arm; all outputs registered.
module capture_ctrl #(
  parameter int AW = 10,
  parameter int DW = 8,
  parameter int PW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sample_en,
  input  logic [DW-1:0] din_sync,
  input  logic          trig,
  input  logic          arm,
  input  logic          abort,
  input  logic          mode_cont,
  input  logic [AW-1:0] pre_samp,
  input  logic [PW-1:0] post_samp,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic [AW-1:0] trig_addr,
  output logic [2:0]    state,
  output logic          capturing,
  output logic          done,
  output logic          wrapped
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_PREFILL = 3'd1;
  localparam logic [2:0] S_ARMED   = 3'd2;
  localparam logic [2:0] S_POST    = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  logic [2:0]    state_nxt;
  logic [AW-1:0] wptr;
  logic [AW-1:0] pre_cnt;
  logic [PW-1:0] post_cnt;
  logic [AW-1:0] pre_l;
  logic [PW-1:0] post_l;
  logic          cont_l;

  logic          in_cap;
  logic          wr_fire;
  logic          restart;
  logic          trig_hit;
  logic [AW-1:0] restart_pre;
  logic          capturing_nxt;
  logic          done_nxt;

  assign in_cap      = (state == S_PREFILL) || (state == S_ARMED) || (state == S_POST);
  assign wr_fire     = in_cap && sample_en;
  // An explicit arm re-latches config; a continuous re-arm reuses what was latched.
  assign restart     = !abort && (arm || (state == S_DONE && cont_l));
  assign restart_pre = arm ? pre_samp : pre_l;
  assign trig_hit    = !abort && !arm && (state == S_ARMED) && trig && sample_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = S_IDLE;
    end else if (restart) begin
      state_nxt = (restart_pre == '0) ? S_ARMED : S_PREFILL;
    end else begin
      case (state)
        S_PREFILL: if (sample_en && pre_cnt == pre_l - AW'(1)) state_nxt = S_ARMED;
        S_ARMED:   if (trig && sample_en) state_nxt = (post_l == '0) ? S_DONE : S_POST;
        S_POST:    if (sample_en && post_cnt == post_l - PW'(1)) state_nxt = S_DONE;
        default:   state_nxt = state;
      endcase
    end
  end

  always_comb begin
    capturing_nxt = (state_nxt == S_PREFILL) || (state_nxt == S_ARMED) || (state_nxt == S_POST);
    done_nxt      = (state != S_DONE) && (state_nxt == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      trig_addr <= '0;
      capturing <= 1'b0;
      done      <= 1'b0;
      wrapped   <= 1'b0;
      wptr      <= '0;
      pre_cnt   <= '0;
      post_cnt  <= '0;
      pre_l     <= '0;
      post_l    <= '0;
      cont_l    <= 1'b0;
    end else begin
      wr_en     <= wr_fire;
      capturing <= capturing_nxt;
      done      <= done_nxt;
      if (wr_fire) begin
        wr_addr <= wptr;
        wr_data <= din_sync;
      end
      // The in-flight write is still issued on arm; only the pointer restarts.
      if (restart) begin
        wptr    <= '0;
        wrapped <= 1'b0;
        pre_cnt <= '0;
      end else begin
        if (wr_fire) begin
          wptr <= wptr + AW'(1);
          if (wptr == {AW{1'b1}}) wrapped <= 1'b1;
        end
        if (state == S_PREFILL && sample_en) pre_cnt <= pre_cnt + AW'(1);
      end
      if (arm && !abort) begin
        pre_l  <= pre_samp;
        post_l <= post_samp;
        cont_l <= mode_cont;
      end
      if (trig_hit) begin
        trig_addr <= wptr;
        post_cnt  <= '0;
      end else if (state == S_POST && sample_en) begin
        post_cnt <= post_cnt + PW'(1);
      end
    end
  end

endmodule

// File: tb/tb_capture_ctrl.sv
// Randomised bench for capture_ctrl: a sample-count reference model feeds expected writes and
// per-cycle status into queues; an independent monitor compares them against the DUT.
module tb_capture_ctrl;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int PW = 16;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sample_en = 1'b0;
  logic [DW-1:0] din_sync = '0;
  logic          trig = 1'b0;
  logic          arm = 1'b0;
  logic          abort = 1'b0;
  logic          mode_cont = 1'b0;
  logic [AW-1:0] pre_samp = '0;
  logic [PW-1:0] post_samp = '0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] trig_addr;
  logic [2:0]    state;
  logic          capturing;
  logic          done;
  logic          wrapped;

  capture_ctrl #(.AW(AW), .DW(DW), .PW(PW)) dut (
    .clk(clk), .rst(rst), .sample_en(sample_en), .din_sync(din_sync), .trig(trig),
    .arm(arm), .abort(abort), .mode_cont(mode_cont), .pre_samp(pre_samp),
    .post_samp(post_samp), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .trig_addr(trig_addr), .state(state), .capturing(capturing), .done(done),
    .wrapped(wrapped)
  );

  always #5 clk = ~clk;

  typedef struct { int addr; int data; int dn; } wexp_t;
  typedef struct { int st; int cap; int wr; int ta; int dn; } sexp_t;
  wexp_t wq[$];
  sexp_t sq[$];

  int errors = 0;
  int checks = 0;

  // Reference model: a capture is described by how many samples it has written (m_n),
  // which sample index was the trigger (m_t), and the config latched at arm.
  bit m_active, m_dst, m_cont, m_wrapped;
  int m_n, m_t, m_pre, m_post, m_taddr;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_active = 0; m_dst = 0; m_cont = 0; m_wrapped = 0;
    m_n = 0; m_t = -1; m_pre = 0; m_post = 0; m_taddr = 0;
  endfunction

  function automatic int model_state();
    if (!m_active) return 0;
    if (m_dst) return 4;
    if (m_t >= 0) return 3;
    if (m_n < m_pre) return 1;
    return 2;
  endfunction

  task automatic cyc(input bit se, input bit tr, input bit ar, input bit ab,
                     input bit cont, input int pre, input int post);
    bit wrote;
    bit done_ev;
    int idx;
    int st;
    wexp_t w;
    sexp_t s;
    @(negedge clk);
    sample_en = se; trig = tr; arm = ar; abort = ab; mode_cont = cont;
    pre_samp = AW'(pre); post_samp = PW'(post); din_sync = DW'($urandom);
    wrote = m_active && !m_dst && se;
    idx = m_n;
    done_ev = 0;
    if (wrote) begin
      m_n++;
      if (m_n >= DEPTH) m_wrapped = 1;
    end
    if (ab) begin
      m_active = 0; m_dst = 0;
    end else if (ar || (m_active && m_dst && m_cont)) begin
      if (ar) begin m_pre = pre; m_post = post; m_cont = cont; end
      m_active = 1; m_dst = 0; m_n = 0; m_t = -1; m_wrapped = 0;
    end else if (wrote) begin
      if (m_t < 0 && idx >= m_pre && tr) begin
        m_t = idx;
        m_taddr = idx % DEPTH;
      end
      if (m_t >= 0 && idx == m_t + m_post) begin
        m_dst = 1;
        done_ev = 1;
      end
    end
    if (wrote) begin
      w.addr = idx % DEPTH; w.data = int'(din_sync); w.dn = int'(done_ev);
      wq.push_back(w);
    end
    st = model_state();
    s.st = st; s.cap = int'(st >= 1 && st <= 3); s.wr = int'(m_wrapped);
    s.ta = m_taddr; s.dn = int'(done_ev);
    sq.push_back(s);
  endtask

  always @(posedge clk) begin
    wexp_t w;
    sexp_t s;
    #1;
    if (wr_en) begin
      if (wq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write: got addr %0d expected no write at %0t", wr_addr, $time);
      end else begin
        w = wq.pop_front();
        chk("wr_addr", int'(wr_addr), w.addr);
        chk("wr_data", int'(wr_data), w.data);
        chk("wr_done", int'(done), w.dn);
      end
    end
    if (sq.size() > 0) begin
      s = sq.pop_front();
      chk("state", int'(state), s.st);
      chk("capturing", int'(capturing), s.cap);
      chk("wrapped", int'(wrapped), s.wr);
      chk("trig_addr", int'(trig_addr), s.ta);
      chk("done", int'(done), s.dn);
    end
  end

  task automatic check_all_zero(string tag);
    chk({tag, "_wr_en"}, int'(wr_en), 0);
    chk({tag, "_wr_addr"}, int'(wr_addr), 0);
    chk({tag, "_wr_data"}, int'(wr_data), 0);
    chk({tag, "_trig_addr"}, int'(trig_addr), 0);
    chk({tag, "_state"}, int'(state), 0);
    chk({tag, "_capturing"}, int'(capturing), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_wrapped"}, int'(wrapped), 0);
  endtask

  initial begin
    model_reset();
    #1;
    check_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Pre-fill of 3 with trig held, then 4 post samples.
    cyc(0, 1, 1, 0, 0, 3, 4);
    for (int i = 0; i < 12; i++) cyc(1, 1, 0, 0, 0, 0, 0);

    // Zero pre/post: trigger on the 6th sample completes immediately.
    cyc(0, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) cyc(1, (i == 5), 0, 0, 0, 0, 0);

    // Sparse sample_en with an unqualified trig before the real one.
    cyc(0, 0, 1, 0, 0, 2, 2);
    for (int i = 1; i < 25; i++) cyc((i % 3 == 0), (i == 7 || i == 9), 0, 0, 0, 0, 0);

    // abort together with arm during POST.
    cyc(0, 0, 1, 0, 0, 1, 10);
    for (int i = 0; i < 5; i++) cyc(1, (i == 2), 0, 0, 0, 0, 0);
    cyc(1, 0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0, 0, 0, 0);

    // Continuous mode with buffer wrap before the trigger.
    cyc(0, 0, 1, 0, 1, 0, 3);
    for (int i = 0; i < 30; i++) cyc(1, (i == 20), 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);

    // Asynchronous reset mid-POST, then no writes until re-armed.
    cyc(0, 0, 1, 0, 0, 0, 20);
    for (int i = 0; i < 6; i++) cyc(1, (i == 1), 0, 0, 0, 0, 0);
    @(negedge clk);
    sample_en = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) cyc(1, 1, 0, 0, 0, 0, 0);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      cyc(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) == 0),
          ($urandom_range(0, 59) == 0), ($urandom_range(0, 149) == 0),
          bit'($urandom_range(0, 1)), $urandom_range(0, 5), $urandom_range(0, 24));
    end

    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0, 0, 0);
    @(negedge clk);
    chk("write_queue_drained", wq.size(), 0);
    chk("status_queue_drained", sq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/capture_ctrl.md
Name: capture_ctrl

Overview:
- Parametrised trigger/capture controller for the logic-probe sample path. Generalises the single-mode sampler with configurable channel width, pre-trigger fill, runtime post-trigger length, and single-shot or continuous re-arm.
- Sits between the input synchroniser and the capture RAM. It generates RAM write strobes and addresses, records the trigger address, and reports capture status to the host interface.

Parameters:
- AW, 10, capture RAM address width; DEPTH = 2^AW.
- DW, 8, sample (channel) width.
- PW, 16, width of the post-trigger count.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- sample_en  in  1  sample strobe; one sample per cycle it is high
- din_sync  in  DW  synchronised channel data
- trig  in  1  trigger condition, qualified by sample_en
- arm  in  1  start capture (pulse)
- abort  in  1  cancel capture (pulse)
- mode_cont  in  1  1 = auto re-arm after done
- pre_samp  in  AW  minimum samples before trigger is accepted
- post_samp  in  PW  samples written after the trigger sample
- wr_en  out  1  RAM write strobe
- wr_addr  out  AW  RAM write address
- wr_data  out  DW  RAM write data
- trig_addr  out  AW  address of the trigger sample
- state  out  3  IDLE=0, PREFILL=1, ARMED=2, POST=3, DONE=4
- capturing  out  1  state is PREFILL, ARMED or POST
- done  out  1  one-cycle pulse when capture completes
- wrapped  out  1  sticky flag: wptr wrapped since last arm

Behaviour:
- Reset (async, immediate): state=IDLE; wptr, wr_addr, wr_data, trig_addr, pre_cnt and post_cnt = 0; wr_en, done, wrapped, capturing = 0.
- All outputs are registered.
- Write path: when state is PREFILL/ARMED/POST and sample_en=1:
  - next edge: wr_en=1, wr_addr=wptr, wr_data=din_sync.
  - wptr increments mod DEPTH; wptr = DEPTH-1 -> 0 sets wrapped.
  - Otherwise wr_en=0.
- Config latch: on arm, pre_samp, post_samp and mode_cont are latched. Input changes during a capture are ignored.
- Priority each cycle: abort > arm > trig.
- abort: any state -> IDLE at next edge; no done; wrapped and trig_addr hold their values; the in-flight write that cycle is still issued if sample_en=1.
- IDLE / DONE + arm:
  - -> PREFILL (or -> ARMED if pre_samp=0).
  - wptr=0, pre_cnt=0, wrapped=0.
  - arm in PREFILL/ARMED/POST restarts the same way.
- PREFILL:
  - each sample_en increments pre_cnt.
  - on the sample where pre_cnt == pre_samp-1: -> ARMED.
  - trig is ignored in PREFILL.
- ARMED, trig && sample_en:
  - this cycle's sample is the trigger sample; trig_addr <= wptr.
  - post_samp=0: -> DONE and done=1 on the same edge as the trigger write.
  - otherwise: post_cnt=0 and -> POST.
- ARMED, trig without sample_en: ignored.
- POST:
  - each sample_en writes and increments post_cnt.
  - on the sample where post_cnt == post_samp-1: -> DONE and done=1 (same edge as the final wr_en).
  - trig is ignored in POST.
- DONE:
  - holds until arm/abort if mode_cont=0.
  - if mode_cont=1: next edge re-enters PREFILL (or ARMED) with wptr=0 and wrapped=0, as for arm.
- Total samples per capture can exceed DEPTH; the buffer simply wraps. wrapped tells the host the whole RAM holds valid data.
- post_cnt saturates never: it is PW bits and compares exactly. post_samp up to 2^PW-1 is supported.

Test Plan:
- AW=4, pre_samp=3, post_samp=4, sample_en=1 continuously, trig held high from arm -> PREFILL for 3 samples (addr 0-2, trig ignored); trigger accepted at addr 3; trig_addr=3; writes addr 4-7; done pulses with the addr-7 write; state=DONE; wrapped=0.
- post_samp=0, pre_samp=0, trig on 6th sample -> trig_addr=5; done on the same edge as the addr-5 write; no further wr_en.
- sample_en every 3rd cycle, pre_samp=2, post_samp=2, trig high in a non-sample cycle then on a sample -> only the qualified trig is accepted; wr_en count = 2+1+2; done aligned to the last strobe.
- abort asserted together with arm during POST -> IDLE next edge; no done; trig_addr retains its value.
- AW=4, mode_cont=1, pre_samp=0, post_samp=3, trig on the 21st sample -> wrapped=1, trig_addr=4, done after addr 7; next edge state=ARMED with wptr=0 and wrapped=0.
- rst asserted asynchronously mid-POST (between edges) -> all outputs 0 and state=IDLE before the next clk edge; no wr_en after release until arm.
